// File: rtl/multiplier_pkg.sv
// -----------------------------------------------------------------------------
// multiplier_pkg
// Shared constants for the shift-and-add multiply-accumulate block:
//   DEF_WIDTH  default operand width
//   CNT_W      width of the iteration counter (WIDTH must stay below 2**CNT_W)
//   S_IDLE / S_RUN / S_DONE  FSM state encoding
// -----------------------------------------------------------------------------
package multiplier_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = 4;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

endpackage : multiplier_pkg

// File: rtl/mac_add8.sv
// -----------------------------------------------------------------------------
// mac_add8
// WIDTH-bit ripple-carry adder with carry-out, used as the accumulate stage of
// the multiplier.
//   x, y  : addends
//   sum   : low WIDTH bits of x + y
//   cout  : carry out of the top bit
// -----------------------------------------------------------------------------
module mac_add8 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign cout = carry[WIDTH];

endmodule : mac_add8

// File: rtl/multiplier.sv
// -----------------------------------------------------------------------------
// multiplier
// Sequential unsigned multiply-accumulate: PROD = m1*m2 + a, computed by a
// radix-2 shift-and-add loop over WIDTH clock cycles.
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   load   : start request; restarts the operation whenever it is high
//   m1     : multiplier operand (unsigned)
//   m2     : multiplicand operand (unsigned)
//   a      : addend (unsigned)
//   PROD   : registered result, written only when an operation completes
//   ready  : PROD holds the result of the most recent load
// -----------------------------------------------------------------------------
module multiplier
  import multiplier_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   m1,
  input  logic [WIDTH-1:0]   m2,
  input  logic [WIDTH-1:0]   a,
  output logic [2*WIDTH-1:0] PROD,
  output logic               ready
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_next;
  logic [WIDTH-1:0]   m2_q;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic               last_iter;

  mac_add8 #(.WIDTH(WIDTH)) u_add (
    .x    (p[2*WIDTH-1:WIDTH]),
    .y    (m2_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The addend preloaded into the upper half of P is shifted down by exactly
  // WIDTH positions over the run, so it lands in the result unscaled. The
  // carry-out re-enters at the MSB, so m1*m2 + a never overflows 2*WIDTH bits.
  always_comb begin
    p_next = {1'b0, p[2*WIDTH-1:1]};
    if (p[0]) begin
      p_next = {add_cout, add_sum, p[WIDTH-1:1]};
    end
  end

  // The final iteration is the edge on which the counter reaches WIDTH; the
  // result is taken from p_next so PROD and ready update on that same edge.
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: every register here is sequential state, so all updates use
  // non-blocking assignments; the reset branch covers every register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      p     <= '0;
      m2_q  <= '0;
      PROD  <= '0;
      ready <= 1'b0;
    end else if (load) begin
      // A load in any state (including mid-run) restarts from scratch; PROD
      // is left untouched so no partial product is ever exposed.
      state <= S_RUN;
      cnt   <= '0;
      p     <= {a, m1};
      m2_q  <= m2;
      ready <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          p   <= p_next;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            PROD  <= p_next;
            ready <= 1'b1;
            state <= S_DONE;
          end
        end
        S_IDLE, S_DONE: begin
          // Hold PROD and ready until the next load.
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : multiplier

// File: tb/tb_multiplier.sv
// -----------------------------------------------------------------------------
// tb_multiplier
// Directed and randomised checks of the multiply-accumulate block at WIDTH=8.
// -----------------------------------------------------------------------------
module tb_multiplier;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [7:0]  m1;
  logic [7:0]  m2;
  logic [7:0]  a;
  logic [15:0] PROD;
  logic        ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] last_prod;

  multiplier #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .m1    (m1),
    .m2    (m2),
    .a     (a),
    .PROD  (PROD),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Called at a falling edge: presents operands with load for one rising
  // edge, then scrambles the operand inputs to prove they were captured.
  task automatic do_load(input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] z);
    m1   = x;
    m2   = y;
    a    = z;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    m1   = 8'($urandom);
    m2   = 8'($urandom);
    a    = 8'($urandom);
  endtask

  // Walks the 8 edges after a load edge: busy with PROD held on edges 1..7,
  // result and ready on edge 8.
  task automatic expect_result(input string tag, input logic [15:0] exp_prod,
                               input logic [15:0] hold_prod);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) begin
        check({tag, " busy"}, 32'(ready), 32'd0);
        check({tag, " hold"}, 32'(PROD), 32'(hold_prod));
      end else begin
        check({tag, " ready"}, 32'(ready), 32'd1);
        check({tag, " prod"}, 32'(PROD), 32'(exp_prod));
      end
    end
  endtask

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  z;
    logic [15:0] expv;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'd13,  8'd11,  8'd5,   16'h0094};
    vecs[1] = '{8'd255, 8'd255, 8'd255, 16'hFF00};
    vecs[2] = '{8'd0,   8'd200, 8'd7,   16'h0007};
    vecs[3] = '{8'd200, 8'd0,   8'd9,   16'h0009};
    vecs[4] = '{8'd1,   8'd1,   8'd0,   16'h0001};
    vecs[5] = '{8'd128, 8'd2,   8'd0,   16'h0100};
    vecs[6] = '{8'd255, 8'd1,   8'd0,   16'h00FF};
    vecs[7] = '{8'd0,   8'd0,   8'd0,   16'h0000};

    // Reset with a simultaneous load: reset must win.
    rst_n = 1'b0;
    load  = 1'b1;
    m1    = 8'd13;
    m2    = 8'd11;
    a     = 8'd5;
    repeat (2) @(negedge clk);
    check("reset prod", 32'(PROD), 32'd0);
    check("reset ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    check("idle prod", 32'(PROD), 32'd0);
    check("idle ready", 32'(ready), 32'd0);
    last_prod = 16'h0000;

    // Directed vectors, including max and zero operands.
    foreach (vecs[i]) begin
      do_load(vecs[i].x, vecs[i].y, vecs[i].z);
      expect_result($sformatf("vec%0d", i), vecs[i].expv, last_prod);
      last_prod = vecs[i].expv;
    end

    // DONE holds indefinitely.
    repeat (5) @(negedge clk);
    check("done hold ready", 32'(ready), 32'd1);
    check("done hold prod", 32'(PROD), 32'(last_prod));

    // Restart mid-run: 0x0094 must never show, only 0x000D.
    do_load(8'd13, 8'd11, 8'd5);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("restart busy", 32'(ready), 32'd0);
      check("restart hold", 32'(PROD), 32'(last_prod));
    end
    do_load(8'd3, 8'd4, 8'd1);
    expect_result("restart", 16'h000D, last_prod);
    last_prod = 16'h000D;

    // Reset mid-run discards the operation and parks in IDLE.
    do_load(8'd13, 8'd11, 8'd5);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst prod", 32'(PROD), 32'd0);
    check("midrst ready", 32'(ready), 32'd0);
    repeat (12) @(negedge clk);
    check("midrst idle prod", 32'(PROD), 32'd0);
    check("midrst idle ready", 32'(ready), 32'd0);
    do_load(8'd2, 8'd2, 8'd0);
    expect_result("after rst", 16'h0004, 16'h0000);
    last_prod = 16'h0004;

    // Load held high for two edges: only the last captured operands count.
    m1   = 8'd9;
    m2   = 8'd9;
    a    = 8'd9;
    load = 1'b1;
    @(negedge clk);
    check("held busy0", 32'(ready), 32'd0);
    m1 = 8'd5;
    m2 = 8'd6;
    a  = 8'd7;
    @(negedge clk);
    check("held busy1", 32'(ready), 32'd0);
    check("held hold", 32'(PROD), 32'(last_prod));
    load = 1'b0;
    m1   = 8'd0;
    m2   = 8'd0;
    a    = 8'd0;
    expect_result("held", 16'h0025, last_prod);
    last_prod = 16'h0025;

    // Divider round-trip: q*d + r with r < d.
    for (int i = 0; i < 200; i++) begin
      int q, d, r;
      logic [15:0] expv;
      q = int'($urandom_range(0, 255));
      d = int'($urandom_range(1, 255));
      r = int'($urandom_range(0, d - 1));
      expv = 16'(q * d + r);
      do_load(8'(q), 8'(d), 8'(r));
      expect_result($sformatf("rand%0d", i), expv, last_prod);
      last_prod = expv;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_multiplier
